// File: rtl/pipeline_ctrl_if.sv
// Hazard-source inputs and latch-control outputs exchanged between the
// 5-stage datapath (master) and the pipeline sequencer (slave).
interface pipeline_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic             ihit;
  logic             dhit;
  logic             dREN_mem;
  logic             dWEN_mem;
  logic             PcSrc_mem;
  logic             JReg_ex;
  logic             JType_id;
  logic             MemToReg_ex;
  logic [4:0]       rd_ex;
  logic [4:0]       rs_id;
  logic [4:0]       rt_id;
  logic             uses_rt_id;
  logic             halt_mem;

  logic             pc_en;
  logic             ifid_en;
  logic             idex_en;
  logic             exmem_en;
  logic             memwb_en;
  logic             ifid_flush;
  logic             idex_flush;
  logic             exmem_flush;
  logic             memwb_flush;
  logic             halt_out;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output ihit, dhit, dREN_mem, dWEN_mem, PcSrc_mem, JReg_ex, JType_id,
           MemToReg_ex, rd_ex, rs_id, rt_id, uses_rt_id, halt_mem,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, memwb_flush,
           halt_out, stall_cnt
  );

  modport slave (
    input  ihit, dhit, dREN_mem, dWEN_mem, PcSrc_mem, JReg_ex, JType_id,
           MemToReg_ex, rd_ex, rs_id, rt_id, uses_rt_id, halt_mem,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, memwb_flush,
           halt_out, stall_cnt
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer: one prioritised decision per cycle drives PC enable and
// the enable/flush pair of every pipeline latch, plus halt drain and stall count.
module pipeline_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input  logic            CLK,
  input  logic            nRST,
  pipeline_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {RUN, DWAIT, DRAIN, HALTED} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic dreq, dstall, lu;
  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic ifid_flush, idex_flush, exmem_flush, memwb_flush;

  assign dreq   = bus.dREN_mem | bus.dWEN_mem;
  assign dstall = dreq & ~bus.dhit;
  assign lu     = bus.MemToReg_ex & (bus.rd_ex != 5'd0) &
                  ((bus.rd_ex == bus.rs_id) |
                   (bus.uses_rt_id & (bus.rd_ex == bus.rt_id)));

  always_comb begin
    state_d     = state_q;
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    memwb_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;

    unique case (state_q)
      RUN, DWAIT: begin
        // DWAIT shares RUN's rule table; only the next state differs, and a
        // pending halt is picked up on the cycle the data access completes.
        state_d = RUN;
        if (dstall) begin
          pc_en       = 1'b0;
          ifid_en     = 1'b0;
          idex_en     = 1'b0;
          exmem_en    = 1'b0;
          memwb_flush = 1'b1;
          state_d     = DWAIT;
        end else if (bus.halt_mem) begin
          pc_en       = 1'b0;
          exmem_flush = 1'b1;
          state_d     = DRAIN;
        end else if (bus.PcSrc_mem) begin
          ifid_flush  = 1'b1;
          idex_flush  = 1'b1;
          exmem_flush = 1'b1;
        end else if (bus.JReg_ex) begin
          ifid_flush  = 1'b1;
          idex_flush  = 1'b1;
        end else if (lu) begin
          pc_en       = 1'b0;
          ifid_en     = 1'b0;
          idex_flush  = 1'b1;
        end else if (bus.JType_id) begin
          ifid_flush  = 1'b1;
        end else if (!bus.ihit) begin
          pc_en       = 1'b0;
          ifid_flush  = 1'b1;
        end
      end
      DRAIN: begin
        pc_en    = 1'b0;
        ifid_en  = 1'b0;
        idex_en  = 1'b0;
        exmem_en = 1'b0;
        state_d  = HALTED;
      end
      HALTED: begin
        pc_en    = 1'b0;
        ifid_en  = 1'b0;
        idex_en  = 1'b0;
        exmem_en = 1'b0;
        memwb_en = 1'b0;
        state_d  = HALTED;
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if ((state_q == RUN || state_q == DWAIT) && !pc_en && (cnt_q != '1))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.pc_en       = pc_en;
  assign bus.ifid_en     = ifid_en;
  assign bus.idex_en     = idex_en;
  assign bus.exmem_en    = exmem_en;
  assign bus.memwb_en    = memwb_en;
  assign bus.ifid_flush  = ifid_flush;
  assign bus.idex_flush  = idex_flush;
  assign bus.exmem_flush = exmem_flush;
  assign bus.memwb_flush = memwb_flush;
  assign bus.halt_out    = (state_q == HALTED);
  assign bus.stall_cnt   = cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Randomised and directed bench for pipeline_ctrl against a rule-table
// reference model that tracks only halt progress and the stall count.
module tb_pipeline_ctrl;

  localparam int unsigned CNT_W = 5;
  localparam longint CNT_MAX = (longint'(1) << CNT_W) - 1;

  logic CLK = 1'b0;
  logic nRST;

  pipeline_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipeline_ctrl #(.CNT_W(CNT_W)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  int n_tot = 0;
  int n_bad = 0;

  // model state: drain pending / halted flags and an unbounded-then-clamped count
  bit     m_drain;
  bit     m_halted;
  longint m_cnt;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // {pc, ifid, idex, exmem, memwb, ifid_f, idex_f, exmem_f, memwb_f}
  function automatic logic [8:0] exp_ctl();
    bit dwait_now, lu;
    if (m_halted) return 9'b00000_0000;
    if (m_drain)  return 9'b00001_0000;
    dwait_now = (bus.dREN_mem || bus.dWEN_mem) && !bus.dhit;
    lu = bus.MemToReg_ex && bus.rd_ex != 0 &&
         (bus.rd_ex == bus.rs_id || (bus.uses_rt_id && bus.rd_ex == bus.rt_id));
    if (dwait_now)         return 9'b00001_0001;
    if (bus.halt_mem)      return 9'b01111_0010;
    if (bus.PcSrc_mem)     return 9'b11111_1110;
    if (bus.JReg_ex)       return 9'b11111_1100;
    if (lu)                return 9'b00111_0100;
    if (bus.JType_id)      return 9'b11111_1000;
    if (!bus.ihit)         return 9'b01111_1000;
    return 9'b11111_0000;
  endfunction

  function automatic logic [8:0] dut_ctl();
    return {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en,
            bus.ifid_flush, bus.idex_flush, bus.exmem_flush, bus.memwb_flush};
  endfunction

  task automatic clear_inputs();
    bus.ihit = 1'b1; bus.dhit = 1'b0; bus.dREN_mem = 1'b0; bus.dWEN_mem = 1'b0;
    bus.PcSrc_mem = 1'b0; bus.JReg_ex = 1'b0; bus.JType_id = 1'b0;
    bus.MemToReg_ex = 1'b0; bus.rd_ex = 5'd0; bus.rs_id = 5'd0; bus.rt_id = 5'd0;
    bus.uses_rt_id = 1'b0; bus.halt_mem = 1'b0;
  endtask

  task automatic rand_inputs(input int halt_pct);
    bus.ihit        = ($urandom_range(99) < 80);
    bus.dhit        = ($urandom_range(99) < 50);
    bus.dREN_mem    = ($urandom_range(99) < 20);
    bus.dWEN_mem    = ($urandom_range(99) < 15);
    bus.PcSrc_mem   = ($urandom_range(99) < 10);
    bus.JReg_ex     = ($urandom_range(99) < 10);
    bus.JType_id    = ($urandom_range(99) < 10);
    bus.MemToReg_ex = ($urandom_range(99) < 35);
    bus.rd_ex       = 5'($urandom_range(3));
    bus.rs_id       = 5'($urandom_range(3));
    bus.rt_id       = 5'($urandom_range(3));
    bus.uses_rt_id  = ($urandom_range(99) < 50);
    bus.halt_mem    = ($urandom_range(99) < halt_pct);
  endtask

  // called at a falling edge with inputs already applied
  task automatic cycle();
    logic [8:0] e;
    #1;
    e = exp_ctl();
    chk("ctl", longint'(dut_ctl()), longint'(e));
    chk("stall_cnt", longint'(bus.stall_cnt), m_cnt);
    chk("halt_out", longint'(bus.halt_out), longint'(m_halted));
    @(posedge CLK);
    if (m_halted) begin
    end else if (m_drain) begin
      m_drain  = 1'b0;
      m_halted = 1'b1;
    end else begin
      if (!e[8] && m_cnt < CNT_MAX) m_cnt++;
      if (!((bus.dREN_mem || bus.dWEN_mem) && !bus.dhit) && bus.halt_mem) m_drain = 1'b1;
    end
    @(negedge CLK);
  endtask

  // asserts reset between edges and checks the immediate effect
  task automatic reset_dut();
    #2 nRST = 1'b0;
    m_drain = 1'b0; m_halted = 1'b0; m_cnt = 0;
    #1;
    chk("rst_halt", longint'(bus.halt_out), 0);
    chk("rst_cnt", longint'(bus.stall_cnt), 0);
    chk("rst_ctl", longint'(dut_ctl()), longint'(exp_ctl()));
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  initial begin
    int halted_run;
    nRST = 1'b0;
    clear_inputs();
    m_drain = 1'b0; m_halted = 1'b0; m_cnt = 0;
    @(negedge CLK);
    chk("por_halt", longint'(bus.halt_out), 0);
    chk("por_cnt", longint'(bus.stall_cnt), 0);
    nRST = 1'b1;

    // load-use bubble, then rd_ex=0 must not stall
    bus.MemToReg_ex = 1'b1; bus.rd_ex = 5'd8; bus.rs_id = 5'd8;
    cycle();
    chk("lu_cnt", longint'(bus.stall_cnt), 1);
    bus.MemToReg_ex = 1'b0;
    cycle();
    bus.MemToReg_ex = 1'b1; bus.rd_ex = 5'd0; bus.rs_id = 5'd0;
    cycle();
    chk("lu_r0_cnt", longint'(bus.stall_cnt), 1);

    // three-cycle dmem wait then completion
    clear_inputs();
    reset_dut();
    bus.dREN_mem = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    bus.dhit = 1'b1;
    cycle();
    chk("dwait_cnt", longint'(bus.stall_cnt), 3);

    // branch beats load-use and ihit miss
    clear_inputs();
    bus.PcSrc_mem = 1'b1; bus.MemToReg_ex = 1'b1; bus.rd_ex = 5'd4;
    bus.rt_id = 5'd4; bus.uses_rt_id = 1'b1; bus.ihit = 1'b0;
    cycle();
    chk("br_lu_cnt", longint'(bus.stall_cnt), 3);

    // dmem stall beats branch; branch flush lands on the dhit cycle
    clear_inputs();
    bus.PcSrc_mem = 1'b1; bus.dWEN_mem = 1'b1;
    cycle();
    bus.dhit = 1'b1;
    cycle();

    // halt colliding with a dmem stall, then drain and halted hold
    clear_inputs();
    bus.halt_mem = 1'b1; bus.dREN_mem = 1'b1;
    cycle();
    bus.dhit = 1'b1;
    cycle();
    clear_inputs();
    cycle();
    for (int i = 0; i < 6; i++) begin
      rand_inputs(50);
      cycle();
    end
    chk("halted_sticky", longint'(bus.halt_out), 1);
    reset_dut();

    // counter saturation under a long fetch miss
    clear_inputs();
    bus.ihit = 1'b0;
    for (int i = 0; i < 40; i++) cycle();
    chk("sat_cnt", longint'(bus.stall_cnt), CNT_MAX);
    reset_dut();

    // randomised run with occasional halts and asynchronous resets
    halted_run = 0;
    for (int i = 0; i < 4000; i++) begin
      rand_inputs(2);
      if (m_halted) halted_run++;
      if (halted_run > 8 || $urandom_range(199) == 0) begin
        halted_run = 0;
        reset_dut();
      end else begin
        cycle();
      end
    end

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Central pipeline sequencer for the 5-stage MIPS core.
- Drives the enable and flush controls of the IF/ID, ID/EX, EX/MEM and MEM/WB latches, and the PC enable.
- Resolves memory waits, load-use hazards, control-flow flushes and the halt drain from one prioritised decision per cycle.
- Sits beside the datapath, between the hazard sources (cache hits, stage decode bits) and the latch control inputs.

Parameters:
- CNT_W, 32, width of the saturating stall-cycle counter.

Ports:
- CLK  in  1  system clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- ihit  in  1  instruction fetch complete this cycle.
- dhit  in  1  data access complete this cycle.
- dREN_mem  in  1  MEM-stage instruction reads dmem.
- dWEN_mem  in  1  MEM-stage instruction writes dmem.
- PcSrc_mem  in  1  taken branch resolved in MEM.
- JReg_ex  in  1  jr in EX.
- JType_id  in  1  j/jal in ID.
- MemToReg_ex  in  1  load in EX.
- rd_ex  in  5  destination register of the EX instruction.
- rs_id  in  5  ID source register rs.
- rt_id  in  5  ID source register rt.
- uses_rt_id  in  1  ID instruction reads rt.
- halt_mem  in  1  halt opcode in MEM.
- pc_en  out  1  PC register load.
- ifid_en, idex_en, exmem_en, memwb_en  out  1 each  latch enables.
- ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1 each  load a bubble (all-zero controls) when the matching enable is 1.
- halt_out  out  1  core halted, sticky.
- stall_cnt  out  CNT_W  count of cycles with pc_en=0 while not halted.

Behaviour:
- Reset (async, nRST=0):
  - state=RUN, stall_cnt=0, halt_out=0.
  - The outputs listed below are combinational from state and inputs, so while reset is held they are the RUN values.
- FSM states: RUN, DWAIT, DRAIN, HALTED.
- Condition definitions:
  - dreq = dREN_mem | dWEN_mem.
  - lu = MemToReg_ex & rd_ex!=0 & (rd_ex==rs_id | (uses_rt_id & rd_ex==rt_id)).
- RUN/DWAIT decision, first matching rule wins; unlisted enables=1, unlisted flushes=0:
  1. dreq & !dhit: pc_en=ifid_en=idex_en=exmem_en=0; memwb_flush=1. Next state DWAIT.
  2. PcSrc_mem: ifid_flush=idex_flush=exmem_flush=1; pc_en=1 regardless of ihit.
  3. JReg_ex: ifid_flush=idex_flush=1; pc_en=1.
  4. lu: pc_en=0, ifid_en=0, idex_flush=1. Exactly one bubble per load-use.
  5. JType_id: ifid_flush=1; pc_en=1.
  6. !ihit: pc_en=0, ifid_flush=1.
- The same rules apply in DWAIT. DWAIT returns to RUN on the first cycle that dhit=1; that cycle all latches advance.
- dreq with dhit=1 in the same cycle never stalls and never leaves RUN.
- Halt drain:
  - halt_mem=1 in RUN, with rule 1 not active: exmem_flush=1 and pc_en=0. State goes to DRAIN.
  - DRAIN: pc_en=ifid_en=idex_en=exmem_en=0; memwb_en=1 for exactly one cycle so the halt reaches WB. Then HALTED.
  - If halt_mem coincides with dreq & !dhit, rule 1 wins and the halt is re-evaluated after dhit.
- HALTED: all enables 0, all flushes 0, halt_out=1. Stays HALTED until nRST=0; no input leaves it.
- stall_cnt:
  - Increments by 1 on each rising edge where pc_en=0 and state is RUN or DWAIT.
  - Saturates at 2^CNT_W-1.
  - Frozen in DRAIN and HALTED.
- Reset mid-operation: state is forced to RUN immediately, regardless of state; the counter clears.
- Flush with enable 0 has no effect; a latch holds whenever its enable is 0.

Test Plan:
- Load-use: MemToReg_ex=1, rd_ex=8, rs_id=8, ihit=1. Required: pc_en=0, ifid_en=0, idex_flush=1 for exactly 1 cycle; stall_cnt 0→1. Repeat with rd_ex=0: no stall.
- Dmem wait: dREN_mem=1, dhit=0 for 3 cycles, then dhit=1. Required: DWAIT for 3 cycles; pc_en/ifid_en/idex_en/exmem_en=0 and memwb_flush=1 in those cycles; full advance on the dhit cycle; stall_cnt=3.
- Branch vs load-use priority: PcSrc_mem=1 together with lu=1 and ihit=0. Required: ifid/idex/exmem_flush=1, pc_en=1, no stall count.
- Dmem beats branch: PcSrc_mem=1, dWEN_mem=1, dhit=0. Required: rule 1 outputs; the branch flush occurs on the dhit cycle.
- Halt drain: halt_mem=1 with dreq=0. Required: next cycle DRAIN with memwb_en=1; following cycle halt_out=1 and all enables 0; ihit toggling causes no change.
- Async reset in HALTED: drop nRST between clock edges. Required: halt_out=0 and stall_cnt=0 immediately; RUN outputs follow.
